// File: rtl/gnrl_pkg.sv
// Shared helpers for the gnrl_* elastic pipeline blocks: the occupancy width
// and the payload-reset selector.
package gnrl_pkg;

  typedef enum logic {
    DATA_KEEP  = 1'b0,
    DATA_CLEAR = 1'b1
  } data_rst_e;

  // Held at a minimum of 1 bit so the DEPTH=0 build still has a legal cnt port.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gnrl_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a payload register that only
// loads when the slot advances with a valid source.
module gnrl_pipe_stage
  import gnrl_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DATA_RST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              adv,
  input  logic              src_vld,
  input  logic [DWIDTH-1:0] src_data,
  output logic              vld,
  output logic [DWIDTH-1:0] data
);

  logic load;

  // Bubbles never toggle the payload, and nothing loads under reset or flush.
  assign load = rst_n & ~flush & adv & src_vld;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= src_vld;
    end
  end

  if (DATA_RST == int'(DATA_CLEAR)) begin : g_data_rst
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data <= '0;
      end else if (load) begin
        data <= src_data;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      if (load) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/gnrl_pipe_vld.sv
// Elastic delay line of DEPTH valid-tagged stages with backpressure, bubble
// collapsing, one-cycle flush and a registered occupancy count.
module gnrl_pipe_vld
  import gnrl_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 4,
  parameter int DATA_RST = 0,
  parameter int CWIDTH   = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DWIDTH-1:0] out_data,
  output logic [CWIDTH-1:0] cnt
);

  genvar gi;

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;

    assign unused_clk = clk;
    assign in_rdy     = out_rdy & rst_n & ~flush;
    assign out_vld    = in_vld & rst_n & ~flush;
    assign out_data   = in_data;
    assign cnt        = '0;
  end else begin : g_pipe
    logic              adv      [DEPTH];
    logic              stg_vld  [DEPTH];
    logic [DWIDTH-1:0] stg_data [DEPTH];
    logic              in_xfer;
    logic              out_xfer;
    logic [CWIDTH-1:0] cnt_reg;

    assign in_rdy   = adv[0] & ~flush & rst_n;
    assign in_xfer  = in_vld & in_rdy;
    assign out_vld  = stg_vld[DEPTH-1] & rst_n & ~flush;
    assign out_xfer = out_vld & out_rdy;
    assign out_data = stg_data[DEPTH-1];

    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              src_vld;
      logic [DWIDTH-1:0] src_data;

      // A slot may move when it is empty or the slot ahead of it moves.
      if (gi == DEPTH - 1) begin : g_tail
        assign adv[gi] = ~stg_vld[gi] | out_rdy;
      end else begin : g_mid
        assign adv[gi] = ~stg_vld[gi] | adv[gi+1];
      end

      if (gi == 0) begin : g_head
        assign src_vld  = in_xfer;
        assign src_data = in_data;
      end else begin : g_body
        assign src_vld  = stg_vld[gi-1];
        assign src_data = stg_data[gi-1];
      end

      gnrl_pipe_stage #(
        .DWIDTH  (DWIDTH),
        .DATA_RST(DATA_RST)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .adv     (adv[gi]),
        .src_vld (src_vld),
        .src_data(src_data),
        .vld     (stg_vld[gi]),
        .data    (stg_data[gi])
      );
    end

    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CWIDTH'(in_xfer) - CWIDTH'(out_xfer);
      end
    end

    assign cnt = cnt_reg;
  end

endmodule

// File: tb/tb_gnrl_pipe_vld.sv
// Bench for gnrl_pipe_vld: a DEPTH=3 build against an ordered queue model of
// beat positions, and a DEPTH=0 build driven with the same stimulus.
module tb_gnrl_pipe_vld;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_vld;
  logic [7:0] in_data;
  logic       out_rdy;

  logic       in_rdy3, out_vld3;
  logic [7:0] out_data3;
  logic [1:0] cnt3;
  logic       in_rdy0, out_vld0;
  logic [7:0] out_data0;
  logic [0:0] cnt0;

  int errors = 0;
  int checks = 0;

  int         qpos[$];
  logic [7:0] qdat[$];

  always #5 clk = ~clk;

  gnrl_pipe_vld #(.DWIDTH(8), .DEPTH(D), .DATA_RST(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy3), .in_data(in_data),
    .out_vld(out_vld3), .out_rdy(out_rdy), .out_data(out_data3), .cnt(cnt3)
  );

  gnrl_pipe_vld #(.DWIDTH(8), .DEPTH(0), .DATA_RST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy0), .in_data(in_data),
    .out_vld(out_vld0), .out_rdy(out_rdy), .out_data(out_data0), .cnt(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check against the model, take the edge, update the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy,
                     input logic fl, input logic rn);
    int  np[$];
    int  lim;
    bit  eov, dep, eir, tail_ok;
    in_vld = v; in_data = d; out_rdy = ordy; flush = fl; rst_n = rn;
    #1;
    eov = rn && !fl && qpos.size() > 0 && qpos[0] == D - 1;
    dep = eov && ordy;
    np = {};
    for (int j = 0; j < qpos.size(); j++) begin
      if (!(j == 0 && dep)) begin
        lim = (np.size() == 0) ? D - 1 : np[np.size()-1] - 1;
        np.push_back((qpos[j] + 1 < lim) ? qpos[j] + 1 : lim);
      end
    end
    tail_ok = (np.size() == 0) || (np[np.size()-1] >= 1);
    eir = rn && !fl && tail_ok;
    chk("in_rdy", 32'(in_rdy3), 32'(eir));
    chk("out_vld", 32'(out_vld3), 32'(eov));
    if (eov) chk("out_data", 32'(out_data3), 32'(qdat[0]));
    chk("cnt", 32'(cnt3), 32'(qpos.size()));
    chk("d0_in_rdy", 32'(in_rdy0), 32'(ordy && rn && !fl));
    chk("d0_out_vld", 32'(out_vld0), 32'(v && rn && !fl));
    chk("d0_out_data", 32'(out_data0), 32'(d));
    chk("d0_cnt", 32'(cnt0), 32'd0);
    $display("cyc t=%0t vld=%0b data=%02h ordy=%0b flush=%0b rst_n=%0b -> in_rdy=%0b out_vld=%0b out_data=%02h cnt=%0d",
             $time, v, d, ordy, fl, rn, in_rdy3, out_vld3, out_data3, cnt3);
    @(posedge clk);
    if (!rn || fl) begin
      qpos.delete();
      qdat.delete();
    end else begin
      if (dep) void'(qdat.pop_front());
      qpos = np;
      if (v && eir) begin
        qpos.push_back(0);
        qdat.push_back(d);
      end
    end
    #2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("rst_data", 32'(out_data3), 32'd0);

    // Unstalled stream of five beats, then drain.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Stall: only three of four beats fit.
    cyc(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h0B, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h0C, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
    chk("stall_cnt", 32'(cnt3), 32'd3);
    chk("stall_in_rdy", 32'(in_rdy3), 32'd0);
    // Full pipe with both sides ready: simultaneous transfer.
    cyc(1'b1, 8'h0D, 1'b1, 1'b0, 1'b1);
    chk("simul_cnt", 32'(cnt3), 32'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Bubbles collapse while stalled.
    cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("bubble_cnt", 32'(cnt3), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Flush with beats in flight.
    cyc(1'b1, 8'h31, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'h32, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    chk("flush_cnt", 32'(cnt3), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream clears valid, count and payload.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h41 + i), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 8'h45, 1'b1, 1'b0, 1'b0);
    chk("midrst_data", 32'(out_data3), 32'd0);
    chk("midrst_cnt", 32'(cnt3), 32'd0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 99) < 65), 8'($urandom), 1'($urandom_range(0, 99) < 60),
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) != 0));
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
